// File: rtl/bit_unreorder_pkg.sv
// Shared definitions for the bit reorder/unreorder family: FSM encodings,
// a clog2 constant function and the identity-map generator.
package bit_unreorder_pkg;

   localparam int MAX_DW = 256;
   localparam int MAX_IW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Flattened map where entry i holds i, packed iw bits per entry.
   function automatic logic [MAX_DW*MAX_IW-1:0] identity_map(input int dw, input int iw);
      logic [MAX_DW*MAX_IW-1:0] m;
      m = '0;
      for (int i = 0; i < dw; i++) begin
         for (int b = 0; b < iw; b++) begin
            m[i*iw + b] = i[b];
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/bit_unreorder_if.sv
// Configuration and streaming handshake bundle of bit_unreorder.
interface bit_unreorder_if #(
   parameter int DATA_WIDTH = 32
);
   import bit_unreorder_pkg::*;
   localparam int IDX_W = clog2(DATA_WIDTH);

   logic                  cfg_wr;
   logic [IDX_W-1:0]      cfg_idx;
   logic [IDX_W-1:0]      cfg_pos;
   logic                  cfg_commit;
   logic                  cfg_busy;
   logic                  map_ok;
   logic                  map_err;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output cfg_wr, cfg_idx, cfg_pos, cfg_commit, in_valid, in_data, out_ready,
      input  cfg_busy, map_ok, map_err, in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_wr, cfg_idx, cfg_pos, cfg_commit, in_valid, in_data, out_ready,
      output cfg_busy, map_ok, map_err, in_ready, out_valid, out_data
   );

endinterface

// File: rtl/bit_unreorder_map_check.sv
// Shadow map table, permutation validator FSM and active-map register.
// The active map is exported flattened, IDX_W bits per entry.
module bit_unreorder_map_check
   import bit_unreorder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   localparam int IDX_W = clog2(DATA_WIDTH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_wr_i,
   input  logic [IDX_W-1:0]            cfg_idx_i,
   input  logic [IDX_W-1:0]            cfg_pos_i,
   input  logic                        cfg_commit_i,
   output logic                        cfg_busy_o,
   output logic                        map_ok_o,
   output logic                        map_err_o,
   output logic [DATA_WIDTH*IDX_W-1:0] active_map_o
);

   localparam int                FLAT_W    = DATA_WIDTH * IDX_W;
   localparam logic [FLAT_W-1:0] IDENT_MAP = FLAT_W'(identity_map(DATA_WIDTH, IDX_W));
   localparam logic [IDX_W:0]    DW_L      = (IDX_W+1)'(DATA_WIDTH);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

   state_e                  state_q;
   logic [IDX_W-1:0]        shadow_q [DATA_WIDTH];
   logic [FLAT_W-1:0]       active_q;
   logic [DATA_WIDTH-1:0]   seen_q;
   logic [IDX_W-1:0]        cnt_q;
   logic                    err_q;
   logic                    busy_q;
   logic                    ok_q;
   logic                    rej_q;

   logic                    wr_en;
   logic [IDX_W-1:0]        cur_pos;
   logic                    pos_in_range;
   logic                    entry_err;

   assign wr_en        = cfg_wr_i && !busy_q && ({1'b0, cfg_idx_i} < DW_L);
   assign cur_pos      = shadow_q[cnt_q];
   assign pos_in_range = {1'b0, cur_pos} < DW_L;
   // Out-of-range positions must not index the seen mask, so range is tested first.
   assign entry_err    = !pos_in_range || seen_q[cur_pos];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         seen_q   <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         ok_q     <= 1'b0;
         rej_q    <= 1'b0;
         active_q <= IDENT_MAP;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            shadow_q[i] <= IDENT_MAP[i*IDX_W +: IDX_W];
         end
      end else begin
         ok_q  <= 1'b0;
         rej_q <= 1'b0;
         if (wr_en) begin
            shadow_q[cfg_idx_i] <= cfg_pos_i;
         end
         case (state_q)
            ST_IDLE: begin
               if (cfg_commit_i) begin
                  state_q <= ST_CHECK;
                  cnt_q   <= '0;
                  seen_q  <= '0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_CHECK: begin
               if (pos_in_range) begin
                  seen_q[cur_pos] <= 1'b1;
               end
               err_q <= err_q | entry_err;
               cnt_q <= cnt_q + IDX_W'(1);
               // Verdict is registered here so the pulse lines up with the DONE cycle.
               if (cnt_q == LAST_IDX) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  ok_q    <= !(err_q | entry_err);
                  rej_q   <= err_q | entry_err;
               end
            end
            ST_DONE: begin
               if (!err_q) begin
                  for (int i = 0; i < DATA_WIDTH; i++) begin
                     active_q[i*IDX_W +: IDX_W] <= shadow_q[i];
                  end
               end
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cfg_busy_o   = busy_q;
   assign map_ok_o     = ok_q;
   assign map_err_o    = rej_q;
   assign active_map_o = active_q;

endmodule

// File: rtl/bit_unreorder.sv
// Streaming inverse bit permutation with a run-time validated map.
// Define BIT_UNREORDER_SKID_EN to replace the output slice with a 2-entry skid buffer.
module bit_unreorder
   import bit_unreorder_pkg::*;
#(
   parameter ARCHITECTURE   = "BEHAVIORAL",
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   bit_unreorder_if.slave bus_if
);

   localparam int IDX_W = clog2(DATA_WIDTH);

   if (ARCHITECTURE == "BEHAVIORAL") begin : g_beh
      logic [DATA_WIDTH*IDX_W-1:0] active_map;
      logic [DATA_WIDTH-1:0]       restored;

      bit_unreorder_map_check #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_map_check (
         .clk          (clk),
         .rst_n        (rst_n),
         .cfg_wr_i     (bus_if.cfg_wr),
         .cfg_idx_i    (bus_if.cfg_idx),
         .cfg_pos_i    (bus_if.cfg_pos),
         .cfg_commit_i (bus_if.cfg_commit),
         .cfg_busy_o   (bus_if.cfg_busy),
         .map_ok_o     (bus_if.map_ok),
         .map_err_o    (bus_if.map_err),
         .active_map_o (active_map)
      );

      // Received bit i is scattered to original position MAP[i].
      always_comb begin
         restored = '0;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            restored[active_map[i*IDX_W +: IDX_W]] = bus_if.in_data[i];
         end
      end

`ifdef BIT_UNREORDER_SKID_EN
      logic [DATA_WIDTH-1:0] mem_q [2];
      logic                  wr_ptr_q;
      logic                  rd_ptr_q;
      logic [1:0]            cnt_q;
      logic [1:0]            cnt_d;
      logic                  in_ready_q;
      logic                  push;
      logic                  pop;

      assign push  = bus_if.in_valid && in_ready_q;
      assign pop   = (cnt_q != 2'd0) && bus_if.out_ready;
      assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

      // in_ready is looked ahead from the next occupancy so it stays a plain flop.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
         end else begin
            if (push) begin
               mem_q[wr_ptr_q] <= restored;
               wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != 2'd2);
         end
      end

      assign bus_if.in_ready  = in_ready_q;
      assign bus_if.out_valid = (cnt_q != 2'd0);
      assign bus_if.out_data  = mem_q[rd_ptr_q];
`else
      logic                  out_valid_q;
      logic                  out_valid_d;
      logic [DATA_WIDTH-1:0] out_data_q;
      logic [DATA_WIDTH-1:0] out_data_d;
      logic                  in_ready;

      assign in_ready = !out_valid_q || bus_if.out_ready;

      always_comb begin
         out_valid_d = out_valid_q;
         out_data_d  = out_data_q;
         if (bus_if.in_valid && in_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = restored;
         end else if (bus_if.out_ready) begin
            out_valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
         end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
         end
      end

      assign bus_if.in_ready  = in_ready;
      assign bus_if.out_valid = out_valid_q;
      assign bus_if.out_data  = out_data_q;
`endif
   end else begin : g_none
      assign bus_if.cfg_busy  = 1'b0;
      assign bus_if.map_ok    = 1'b0;
      assign bus_if.map_err   = 1'b0;
      assign bus_if.in_ready  = 1'b0;
      assign bus_if.out_valid = 1'b0;
      assign bus_if.out_data  = '0;
   end

endmodule

// File: tb/tb_bit_unreorder.sv
// Randomized self-checking bench for bit_unreorder against a map-level model.
module tb_bit_unreorder;

   typedef int map_t [8];

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   map_t act_m;
   map_t shd_m;

   bit_unreorder_if #(.DATA_WIDTH(8)) b8();
   bit_unreorder_if #(.DATA_WIDTH(6)) b6();

   bit_unreorder #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus_if(b8.slave));
   bit_unreorder #(.DATA_WIDTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus_if(b6.slave));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] remap(input logic [7:0] d, input map_t m);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[m[i]] = d[i];
      return r;
   endfunction

   function automatic bit shadow_is_perm();
      int hits [8];
      foreach (hits[j]) hits[j] = 0;
      for (int i = 0; i < 8; i++) begin
         if (shd_m[i] < 0 || shd_m[i] > 7) return 1'b0;
         hits[shd_m[i]]++;
      end
      foreach (hits[j]) if (hits[j] != 1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic map_t random_perm();
      map_t p;
      int j, t;
      for (int i = 0; i < 8; i++) p[i] = i;
      for (int i = 7; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = p[i]; p[i] = p[j]; p[j] = t;
      end
      if (p[0] == 0 && p[1] == 1) begin
         p[0] = 1; p[1] = 0;
      end
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_identity_model();
      for (int i = 0; i < 8; i++) begin
         act_m[i] = i;
         shd_m[i] = i;
      end
   endtask

   task automatic cfg_write8(input int idx, input int pos);
      b8.cfg_wr  = 1'b1;
      b8.cfg_idx = 3'(idx);
      b8.cfg_pos = 3'(pos);
      tick();
      b8.cfg_wr  = 1'b0;
      shd_m[idx] = pos;
   endtask

   task automatic write_map8(input map_t m);
      for (int i = 0; i < 8; i++) cfg_write8(i, m[i]);
   endtask

   // Commit the shadow map and record what the DUT does over the next 16 cycles.
   task automatic do_commit8(output int busy_first, output int busy_last, output int busy_n,
                             output int ok_cyc, output int err_cyc, output int n_pulses);
      busy_first = -1; busy_last = -1; busy_n = 0;
      ok_cyc = -1; err_cyc = -1; n_pulses = 0;
      b8.cfg_commit = 1'b1;
      tick();
      b8.cfg_commit = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (b8.cfg_busy === 1'b1) begin
            if (busy_first < 0) busy_first = k;
            busy_last = k;
            busy_n++;
         end
         if (b8.map_ok === 1'b1) begin ok_cyc = k; n_pulses++; end
         if (b8.map_err === 1'b1) begin err_cyc = k; n_pulses++; end
         tick();
      end
      if (shadow_is_perm()) act_m = shd_m;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (b8.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b8.out_valid); end
      checks++; if (b8.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", b8.out_data); end
      checks++; if (b8.cfg_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", b8.cfg_busy); end
      checks++; if (b8.map_ok !== 1'b0 || b8.map_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", b8.map_ok, b8.map_err); end
      checks++; if (b8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", b8.in_ready); end
      rst_n = 1'b1;
      set_identity_model();
      tick();
   endtask

   task automatic test_identity();
      logic [7:0] d;
      b8.out_ready = 1'b1;
      b8.in_valid  = 1'b1;
      b8.in_data   = 8'hA5;
      tick();
      b8.in_valid = 1'b0;
      checks++; if (b8.out_valid !== 1'b1 || b8.out_data !== 8'hA5) begin failures++; $display("FAIL ident_a5 got=%b/%h exp=1/a5", b8.out_valid, b8.out_data); end
      checks++; if (b8.in_ready !== 1'b1) begin failures++; $display("FAIL ident_in_ready got=%b exp=1", b8.in_ready); end
      for (int n = 0; n < 4; n++) begin
         d = 8'($urandom);
         b8.in_valid = 1'b1;
         b8.in_data  = d;
         tick();
         checks++; if (b8.out_valid !== 1'b1 || b8.out_data !== remap(d, act_m)) begin failures++; $display("FAIL ident_rand got=%h exp=%h", b8.out_data, remap(d, act_m)); end
      end
      b8.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_duplicate();
      int bf, bl, bn, okc, erc, np;
      map_t m;
      for (int i = 0; i < 8; i++) m[i] = i;
      m[0] = 3; m[1] = 3;
      write_map8(m);
      do_commit8(bf, bl, bn, okc, erc, np);
      checks++; if (erc != 9 || okc != -1 || np != 1) begin failures++; $display("FAIL dup_pulse got=err@%0d ok@%0d n=%0d exp=err@9 ok@-1 n=1", erc, okc, np); end
      checks++; if (bf != 1 || bl != 8 || bn != 8) begin failures++; $display("FAIL dup_busy got=%0d..%0d n=%0d exp=1..8 n=8", bf, bl, bn); end
      b8.in_valid = 1'b1;
      b8.in_data  = 8'h01;
      tick();
      b8.in_valid = 1'b0;
      checks++; if (b8.out_data !== remap(8'h01, act_m)) begin failures++; $display("FAIL dup_old_map got=%h exp=%h", b8.out_data, remap(8'h01, act_m)); end
      tick();
   endtask

   task automatic test_reversal();
      int bf, bl, bn, okc, erc, np;
      logic [7:0] d;
      map_t m;
      for (int i = 0; i < 8; i++) m[i] = 7 - i;
      write_map8(m);
      do_commit8(bf, bl, bn, okc, erc, np);
      checks++; if (okc != 9 || erc != -1 || np != 1) begin failures++; $display("FAIL rev_pulse got=ok@%0d err@%0d n=%0d exp=ok@9 err@-1 n=1", okc, erc, np); end
      checks++; if (bf != 1 || bl != 8 || bn != 8) begin failures++; $display("FAIL rev_busy got=%0d..%0d n=%0d exp=1..8 n=8", bf, bl, bn); end
      b8.in_valid = 1'b1;
      b8.in_data  = 8'h01;
      tick();
      checks++; if (b8.out_data !== remap(8'h01, act_m)) begin failures++; $display("FAIL rev_01 got=%h exp=%h", b8.out_data, remap(8'h01, act_m)); end
      for (int n = 0; n < 4; n++) begin
         d = 8'($urandom);
         b8.in_data = d;
         tick();
         checks++; if (b8.out_data !== remap(d, act_m)) begin failures++; $display("FAIL rev_rand got=%h exp=%h", b8.out_data, remap(d, act_m)); end
      end
      b8.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_out_of_range();
      int erc = -1, okc = -1, bn = 0;
      logic [5:0] d;
      b6.cfg_wr  = 1'b1;
      b6.cfg_idx = 3'd2;
      b6.cfg_pos = 3'd7;
      tick();
      b6.cfg_wr     = 1'b0;
      b6.cfg_commit = 1'b1;
      tick();
      b6.cfg_commit = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (b6.cfg_busy === 1'b1) bn++;
         if (b6.map_err === 1'b1) erc = k;
         if (b6.map_ok === 1'b1) okc = k;
         tick();
      end
      checks++; if (erc != 7 || okc != -1) begin failures++; $display("FAIL oor_pulse got=err@%0d ok@%0d exp=err@7 ok@-1", erc, okc); end
      checks++; if (bn != 6) begin failures++; $display("FAIL oor_busy got=%0d exp=6", bn); end
      d = 6'($urandom);
      b6.in_valid = 1'b1;
      b6.in_data  = d;
      tick();
      b6.in_valid = 1'b0;
      checks++; if (b6.out_data !== d) begin failures++; $display("FAIL oor_identity got=%h exp=%h", b6.out_data, d); end
      tick();
   endtask

   task automatic test_switchover();
      map_t old_m, new_m;
      logic [7:0] d, exp;
      int ok_at = -1;
      old_m = act_m;
      new_m = random_perm();
      write_map8(new_m);
      b8.out_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         d = 8'($urandom);
         b8.in_valid   = 1'b1;
         b8.in_data    = d;
         b8.cfg_commit = (c == 0);
         #1;
         checks++; if (b8.in_ready !== 1'b1) begin failures++; $display("FAIL sw_bubble c=%0d got=%b exp=1", c, b8.in_ready); end
         tick();
         b8.cfg_commit = 1'b0;
         if (b8.map_ok === 1'b1) ok_at = c;
         exp = (c <= 9) ? remap(d, old_m) : remap(d, new_m);
         checks++; if (b8.out_valid !== 1'b1 || b8.out_data !== exp) begin failures++; $display("FAIL sw_word c=%0d got=%b/%h exp=1/%h", c, b8.out_valid, b8.out_data, exp); end
      end
      b8.in_valid = 1'b0;
      checks++; if (ok_at != 8) begin failures++; $display("FAIL sw_ok got=%0d exp=8", ok_at); end
      act_m = new_m;
      tick();
   endtask

   task automatic test_backpressure();
      logic [7:0] q [$];
      logic [7:0] cur, exp;
      int sent = 0, popped = 0, exp_acc;
`ifdef BIT_UNREORDER_SKID_EN
      exp_acc = 2;
`else
      exp_acc = 1;
`endif
      cur = 8'($urandom);
      for (int cyc = 0; cyc < 15; cyc++) begin
         b8.out_ready = (cyc >= 5);
         b8.in_valid  = (sent < 4);
         b8.in_data   = cur;
         #1;
         if (cyc >= 1 && cyc <= 4) begin
            checks++; if (b8.out_valid !== 1'b1 || q.size() == 0 || b8.out_data !== q[0]) begin failures++; $display("FAIL bp_stall_hold cyc=%0d got=%b/%h", cyc, b8.out_valid, b8.out_data); end
         end
         if (cyc == 4) begin
            checks++; if (b8.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", b8.in_ready); end
            checks++; if (sent != exp_acc) begin failures++; $display("FAIL bp_accepts got=%0d exp=%0d", sent, exp_acc); end
         end
         if (b8.out_valid && b8.out_ready) begin
            checks++;
            if (q.size() == 0) begin failures++; $display("FAIL bp_dup got=%h exp=none", b8.out_data); end
            else begin
               exp = q.pop_front();
               popped++;
               if (b8.out_data !== exp) begin failures++; $display("FAIL bp_data got=%h exp=%h", b8.out_data, exp); end
            end
         end
         if (b8.in_valid && b8.in_ready) begin
            q.push_back(remap(cur, act_m));
            sent++;
            cur = 8'($urandom);
         end
         @(posedge clk);
         #1;
      end
      checks++; if (q.size() != 0 || popped != 4) begin failures++; $display("FAIL bp_loss got=popped %0d left %0d exp=popped 4 left 0", popped, q.size()); end
   endtask

   task automatic test_random_stream();
      logic [7:0] q [$];
      logic [7:0] cur, exp;
      cur = 8'($urandom);
      for (int cyc = 0; cyc < 160; cyc++) begin
         b8.in_valid  = (cyc < 150) && ($urandom_range(9, 0) < 7);
         b8.in_data   = cur;
         b8.out_ready = (cyc >= 150) || ($urandom_range(9, 0) < 7);
         #1;
         if (b8.out_valid && b8.out_ready) begin
            checks++;
            if (q.size() == 0) begin failures++; $display("FAIL rand_extra got=%h exp=none", b8.out_data); end
            else begin
               exp = q.pop_front();
               if (b8.out_data !== exp) begin failures++; $display("FAIL rand_data got=%h exp=%h", b8.out_data, exp); end
            end
         end
         if (b8.in_valid && b8.in_ready) begin
            q.push_back(remap(cur, act_m));
            cur = 8'($urandom);
         end
         @(posedge clk);
         #1;
      end
      checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_loss got=%0d exp=0", q.size()); end
      b8.in_valid  = 1'b0;
      b8.out_ready = 1'b1;
   endtask

   task automatic test_busy_write();
      map_t p;
      int okc = -1, np = 0;
      logic [7:0] d;
      p = random_perm();
      write_map8(p);
      b8.cfg_commit = 1'b1;
      tick();
      b8.cfg_commit = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         b8.cfg_wr     = (k == 3);
         b8.cfg_idx    = 3'd0;
         b8.cfg_pos    = 3'(shd_m[1]);
         b8.cfg_commit = (k == 3);
         if (b8.map_ok === 1'b1) begin okc = k; np++; end
         if (b8.map_err === 1'b1) np++;
         tick();
      end
      b8.cfg_wr     = 1'b0;
      b8.cfg_commit = 1'b0;
      checks++; if (okc != 9 || np != 1) begin failures++; $display("FAIL busy_wr got=ok@%0d n=%0d exp=ok@9 n=1", okc, np); end
      act_m = p;
      d = 8'($urandom);
      b8.in_valid = 1'b1;
      b8.in_data  = d;
      tick();
      b8.in_valid = 1'b0;
      checks++; if (b8.out_data !== remap(d, act_m)) begin failures++; $display("FAIL busy_wr_map got=%h exp=%h", b8.out_data, remap(d, act_m)); end
      tick();
   endtask

   task automatic test_reset_mid_check();
      int bf, bl, bn, okc, erc, np;
      int pulses = 0, busy_seen = 0;
      logic [7:0] d;
      b8.out_ready  = 1'b0;
      b8.in_valid   = 1'b1;
      b8.in_data    = 8'($urandom);
      b8.cfg_commit = 1'b1;
      tick();
      b8.cfg_commit = 1'b0;
      b8.in_valid   = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (b8.out_valid !== 1'b0 || b8.cfg_busy !== 1'b0) begin failures++; $display("FAIL rmid_clear got=%b/%b exp=0/0", b8.out_valid, b8.cfg_busy); end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      set_identity_model();
      b8.out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (b8.map_ok === 1'b1 || b8.map_err === 1'b1) pulses++;
         if (b8.cfg_busy === 1'b1) busy_seen++;
         tick();
      end
      checks++; if (pulses != 0 || busy_seen != 0) begin failures++; $display("FAIL rmid_quiet got=pulses %0d busy %0d exp=0 0", pulses, busy_seen); end
      d = 8'($urandom);
      b8.in_valid = 1'b1;
      b8.in_data  = d;
      tick();
      b8.in_valid = 1'b0;
      checks++; if (b8.out_data !== d) begin failures++; $display("FAIL rmid_identity got=%h exp=%h", b8.out_data, d); end
      do_commit8(bf, bl, bn, okc, erc, np);
      checks++; if (okc != 9 || np != 1) begin failures++; $display("FAIL rmid_recommit got=ok@%0d n=%0d exp=ok@9 n=1", okc, np); end
      d = 8'($urandom);
      b8.in_valid = 1'b1;
      b8.in_data  = d;
      tick();
      b8.in_valid = 1'b0;
      checks++; if (b8.out_data !== remap(d, act_m) || b8.out_data !== d) begin failures++; $display("FAIL rmid_shadow got=%h exp=%h", b8.out_data, d); end
      tick();
   endtask

   initial begin
      rst_n         = 1'b0;
      b8.cfg_wr     = 1'b0; b8.cfg_idx = '0; b8.cfg_pos = '0; b8.cfg_commit = 1'b0;
      b8.in_valid   = 1'b0; b8.in_data = '0; b8.out_ready = 1'b1;
      b6.cfg_wr     = 1'b0; b6.cfg_idx = '0; b6.cfg_pos = '0; b6.cfg_commit = 1'b0;
      b6.in_valid   = 1'b0; b6.in_data = '0; b6.out_ready = 1'b1;
      set_identity_model();
      test_reset();
      test_identity();
      test_duplicate();
      test_reversal();
      test_out_of_range();
      test_switchover();
      test_backpressure();
      test_random_stream();
      test_busy_write();
      test_reset_mid_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
